// File: rtl/reaction_round_if.sv
// Signal bundle between the reaction round sequencer and the button/counter/display datapath.
// The sequencer connects through the slave modport; the datapath or stimulus side uses master.
interface reaction_round_if;
    logic        btn_go;
    logic [13:0] rand_val;
    logic [13:0] count_val;
    logic [1:0]  select;
    logic [13:0] target;
    logic        cnt_clr;
    logic        cnt_en;
    logic [2:0]  round_idx;
    logic [13:0] round_err;
    logic [15:0] total_err;
    logic [13:0] best_err;
    logic        done;

    modport master (
        output btn_go, rand_val, count_val,
        input  select, target, cnt_clr, cnt_en, round_idx,
        input  round_err, total_err, best_err, done
    );

    modport slave (
        input  btn_go, rand_val, count_val,
        output select, target, cnt_clr, cnt_en, round_idx,
        output round_err, total_err, best_err, done
    );
endinterface

// File: rtl/reaction_round_sequencer.sv
// Multi-round reaction game controller: target latch, counting and scoring over NUM_ROUNDS rounds.
// Optional macro FALSE_START_EN: a press during the minimum SHOW dwell scores 9999 and skips COUNT.
//
// state   | meaning
// IDLE    | waiting for a press to start a game
// SHOW    | target displayed, minimum dwell running
// COUNT   | counter enabled, waiting for press or timeout
// SCORE   | one cycle, accumulate total and best error
// GAP     | pause between rounds
// DONE    | game over, results held until a press
module reaction_round_sequencer #(
    parameter int NUM_ROUNDS     = 3,
    parameter int GAP_TICKS      = 20000000,
    parameter int TIMEOUT_COUNT  = 9999,
    parameter int MIN_SHOW_TICKS = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    reaction_round_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SHOW, S_COUNT, S_SCORE, S_GAP, S_DONE
    } state_t;

    localparam logic [13:0] ERR_MAX     = 14'd9999;
    localparam logic [13:0] TIMEOUT_VAL = 14'(TIMEOUT_COUNT);
    localparam logic [31:0] SHOW_LOAD   = 32'(MIN_SHOW_TICKS);
    localparam logic [31:0] GAP_LOAD    = 32'(GAP_TICKS);
    localparam logic [2:0]  LAST_ROUND  = 3'(NUM_ROUNDS - 1);

    state_t      state;
    logic        btn_q;
    logic [31:0] dwell_cnt;
    logic [31:0] gap_cnt;
    logic [1:0]  select;
    logic [13:0] target;
    logic        cnt_clr;
    logic        cnt_en;
    logic [2:0]  round_idx;
    logic [13:0] round_err;
    logic [15:0] total_err;
    logic [13:0] best_err;
    logic        done;

    logic        press;
    logic [13:0] abs_diff;
    logic [16:0] total_sum;

    // Map any 14-bit random value into the displayable 1000..9999 range
    function automatic logic [13:0] fold(input logic [13:0] r);
        logic [13:0] t;
        t = r;
        if (t < 14'd1000) t = t + 14'd1000;
        if (t > 14'd9999) t = t - 14'd7000;
        return t;
    endfunction

    always_comb begin
        press     = bus.btn_go & ~btn_q;
        abs_diff  = (bus.count_val >= target) ? (bus.count_val - target)
                                              : (target - bus.count_val);
        total_sum = {1'b0, total_err} + {3'b000, round_err};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            btn_q     <= 1'b1;
            dwell_cnt <= '0;
            gap_cnt   <= '0;
            select    <= 2'd0;
            target    <= '0;
            cnt_clr   <= 1'b0;
            cnt_en    <= 1'b0;
            round_idx <= '0;
            round_err <= '0;
            total_err <= '0;
            best_err  <= ERR_MAX;
            done      <= 1'b0;
        end else begin
            btn_q   <= bus.btn_go;
            cnt_clr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (press) begin
                        state     <= S_SHOW;
                        select    <= 2'd1;
                        total_err <= '0;
                        round_idx <= '0;
                        target    <= fold(bus.rand_val);
                        dwell_cnt <= SHOW_LOAD;
                    end
                end
                S_SHOW: begin
                    if (dwell_cnt != 32'd0) dwell_cnt <= dwell_cnt - 32'd1;
                    if (press && dwell_cnt == 32'd0) begin
                        state   <= S_COUNT;
                        select  <= 2'd2;
                        cnt_clr <= 1'b1;
                        cnt_en  <= 1'b1;
                    end
`ifdef FALSE_START_EN
                    else if (press) begin
                        state     <= S_SCORE;
                        select    <= 2'd3;
                        round_err <= ERR_MAX;
                    end
`endif
                end
                S_COUNT: begin
                    // A press coincident with the timeout still earns its real error
                    if (press) begin
                        state     <= S_SCORE;
                        select    <= 2'd3;
                        cnt_en    <= 1'b0;
                        round_err <= abs_diff;
                    end else if (bus.count_val == TIMEOUT_VAL) begin
                        state     <= S_SCORE;
                        select    <= 2'd3;
                        cnt_en    <= 1'b0;
                        round_err <= ERR_MAX;
                    end
                end
                S_SCORE: begin
                    total_err <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
                    if (round_err < best_err) best_err <= round_err;
                    gap_cnt <= GAP_LOAD;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt <= 32'd1) begin
                        if (round_idx == LAST_ROUND) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_SHOW;
                            select    <= 2'd1;
                            round_idx <= round_idx + 3'd1;
                            target    <= fold(bus.rand_val);
                            dwell_cnt <= SHOW_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 32'd1;
                    end
                end
                S_DONE: begin
                    if (press) begin
                        state  <= S_IDLE;
                        select <= 2'd0;
                        done   <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    select <= 2'd0;
                    cnt_en <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.select    = select;
    assign bus.target    = target;
    assign bus.cnt_clr   = cnt_clr;
    assign bus.cnt_en    = cnt_en;
    assign bus.round_idx = round_idx;
    assign bus.round_err = round_err;
    assign bus.total_err = total_err;
    assign bus.best_err  = best_err;
    assign bus.done      = done;
endmodule

// File: tb/tb_reaction_round_sequencer.sv
// Directed bench for reaction_round_sequencer with shortened dwell and gap timers.
module tb_reaction_round_sequencer;
    localparam int GAP  = 5;
    localparam int MINS = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reaction_round_if bus();

    reaction_round_sequencer #(
        .NUM_ROUNDS(3), .GAP_TICKS(GAP), .TIMEOUT_COUNT(9999), .MIN_SHOW_TICKS(MINS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.btn_go = 1'b0;
        bus.count_val = 14'd0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic press_step();
        bus.btn_go = 1'b1;
        step(1);
        bus.btn_go = 1'b0;
    endtask

    task automatic start_game(input logic [13:0] r);
        bus.rand_val = r;
        press_step();
    endtask

    task automatic enter_count();
        bus.count_val = 14'd0;
        step(MINS + 2);
        press_step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.btn_go = 1'b1;
        bus.rand_val = 14'd0;
        bus.count_val = 14'd0;
        step(3);
        checks++; if (bus.select !== 2'd0) begin errors++; $display("FAIL rst_select got %0d exp 0", bus.select); end
        checks++; if (bus.target !== 14'd0) begin errors++; $display("FAIL rst_target got %0d exp 0", bus.target); end
        checks++; if (bus.cnt_clr !== 1'b0 || bus.cnt_en !== 1'b0) begin errors++; $display("FAIL rst_cnt got clr=%0b en=%0b exp 0 0", bus.cnt_clr, bus.cnt_en); end
        checks++; if (bus.round_idx !== 3'd0 || bus.round_err !== 14'd0) begin errors++; $display("FAIL rst_round got idx=%0d err=%0d exp 0 0", bus.round_idx, bus.round_err); end
        checks++; if (bus.total_err !== 16'd0) begin errors++; $display("FAIL rst_total got %0d exp 0", bus.total_err); end
        checks++; if (bus.best_err !== 14'd9999) begin errors++; $display("FAIL rst_best got %0d exp 9999", bus.best_err); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", bus.done); end
        rst = 1'b0;
        step(3);
        checks++; if (bus.select !== 2'd0) begin errors++; $display("FAIL held_btn_no_press got select=%0d exp 0", bus.select); end
        bus.btn_go = 1'b0;
        step(1);
        press_step();
        checks++; if (bus.select !== 2'd1) begin errors++; $display("FAIL first_press_select got %0d exp 1", bus.select); end
        checks++; if (bus.target !== 14'd1000) begin errors++; $display("FAIL first_press_target got %0d exp 1000", bus.target); end
    endtask

    task automatic test_target_fold();
        logic [13:0] rv [6];
        logic [13:0] tv [6];
        rv = '{14'd500, 14'd12000, 14'd9999, 14'd999, 14'd16383, 14'd1000};
        tv = '{14'd1500, 14'd5000, 14'd9999, 14'd1999, 14'd9383, 14'd1000};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            start_game(rv[i]);
            checks++; if (bus.select !== 2'd1) begin errors++; $display("FAIL fold_select[%0d] got %0d exp 1", i, bus.select); end
            checks++; if (bus.target !== tv[i]) begin errors++; $display("FAIL fold_target rand=%0d got %0d exp %0d", rv[i], bus.target, tv[i]); end
        end
    endtask

    task automatic test_early_press();
        do_reset();
        start_game(14'd3000);
        step(9);
        press_step();
`ifdef FALSE_START_EN
        checks++; if (bus.select !== 2'd3) begin errors++; $display("FAIL false_start_select got %0d exp 3", bus.select); end
        checks++; if (bus.round_err !== 14'd9999) begin errors++; $display("FAIL false_start_err got %0d exp 9999", bus.round_err); end
        checks++; if (bus.cnt_clr !== 1'b0 || bus.cnt_en !== 1'b0) begin errors++; $display("FAIL false_start_cnt got clr=%0b en=%0b exp 0 0", bus.cnt_clr, bus.cnt_en); end
        step(1);
        checks++; if (bus.total_err !== 16'd9999) begin errors++; $display("FAIL false_start_total got %0d exp 9999", bus.total_err); end
        checks++; if (bus.cnt_en !== 1'b0) begin errors++; $display("FAIL false_start_en_gap got %0b exp 0", bus.cnt_en); end
`else
        checks++; if (bus.select !== 2'd1) begin errors++; $display("FAIL early_press_select got %0d exp 1", bus.select); end
        checks++; if (bus.cnt_clr !== 1'b0 || bus.cnt_en !== 1'b0) begin errors++; $display("FAIL early_press_cnt got clr=%0b en=%0b exp 0 0", bus.cnt_clr, bus.cnt_en); end
        step(MINS);
        press_step();
        checks++; if (bus.select !== 2'd2 || bus.cnt_clr !== 1'b1) begin errors++; $display("FAIL late_press_accept got select=%0d clr=%0b exp 2 1", bus.select, bus.cnt_clr); end
`endif
    endtask

    task automatic test_round_scoring();
        do_reset();
        start_game(14'd5000);
        checks++; if (bus.target !== 14'd5000) begin errors++; $display("FAIL r0_target got %0d exp 5000", bus.target); end
        enter_count();
        checks++; if (bus.select !== 2'd2 || bus.cnt_clr !== 1'b1 || bus.cnt_en !== 1'b1) begin errors++; $display("FAIL r0_count_entry got select=%0d clr=%0b en=%0b exp 2 1 1", bus.select, bus.cnt_clr, bus.cnt_en); end
        step(1);
        checks++; if (bus.cnt_clr !== 1'b0 || bus.cnt_en !== 1'b1) begin errors++; $display("FAIL r0_clr_pulse got clr=%0b en=%0b exp 0 1", bus.cnt_clr, bus.cnt_en); end
        bus.count_val = 14'd5120;
        press_step();
        checks++; if (bus.select !== 2'd3 || bus.round_err !== 14'd120 || bus.cnt_en !== 1'b0) begin errors++; $display("FAIL r0_score got select=%0d err=%0d en=%0b exp 3 120 0", bus.select, bus.round_err, bus.cnt_en); end
        step(1);
        checks++; if (bus.total_err !== 16'd120 || bus.best_err !== 14'd120) begin errors++; $display("FAIL r0_accum got total=%0d best=%0d exp 120 120", bus.total_err, bus.best_err); end
        bus.rand_val = 14'd12000;
        step(GAP - 1);
        checks++; if (bus.select !== 2'd3) begin errors++; $display("FAIL r0_gap_hold got select=%0d exp 3", bus.select); end
        step(1);
        checks++; if (bus.select !== 2'd1 || bus.round_idx !== 3'd1 || bus.target !== 14'd5000) begin errors++; $display("FAIL r1_start got select=%0d idx=%0d target=%0d exp 1 1 5000", bus.select, bus.round_idx, bus.target); end

        enter_count();
        step(2);
        bus.count_val = 14'd9998;
        step(1);
        checks++; if (bus.select !== 2'd2) begin errors++; $display("FAIL r1_no_early_timeout got select=%0d exp 2", bus.select); end
        bus.count_val = 14'd9999;
        step(1);
        checks++; if (bus.select !== 2'd3 || bus.round_err !== 14'd9999 || bus.cnt_en !== 1'b0) begin errors++; $display("FAIL r1_timeout got select=%0d err=%0d en=%0b exp 3 9999 0", bus.select, bus.round_err, bus.cnt_en); end
        step(1);
        checks++; if (bus.total_err !== 16'd10119 || bus.best_err !== 14'd120) begin errors++; $display("FAIL r1_accum got total=%0d best=%0d exp 10119 120", bus.total_err, bus.best_err); end
        bus.rand_val = 14'd9000;
        step(GAP);
        checks++; if (bus.round_idx !== 3'd2 || bus.target !== 14'd9000) begin errors++; $display("FAIL r2_start got idx=%0d target=%0d exp 2 9000", bus.round_idx, bus.target); end

        enter_count();
        step(1);
        bus.count_val = 14'd9999;
        press_step();
        checks++; if (bus.select !== 2'd3 || bus.round_err !== 14'd999) begin errors++; $display("FAIL r2_press_beats_timeout got select=%0d err=%0d exp 3 999", bus.select, bus.round_err); end
        step(1);
        checks++; if (bus.total_err !== 16'd11118 || bus.best_err !== 14'd120) begin errors++; $display("FAIL r2_accum got total=%0d best=%0d exp 11118 120", bus.total_err, bus.best_err); end
        step(GAP);
        checks++; if (bus.done !== 1'b1 || bus.select !== 2'd3 || bus.round_idx !== 3'd2) begin errors++; $display("FAIL game_done got done=%0b select=%0d idx=%0d exp 1 3 2", bus.done, bus.select, bus.round_idx); end
        step(3);
        checks++; if (bus.done !== 1'b1 || bus.total_err !== 16'd11118) begin errors++; $display("FAIL done_hold got done=%0b total=%0d exp 1 11118", bus.done, bus.total_err); end
        press_step();
        checks++; if (bus.select !== 2'd0 || bus.done !== 1'b0 || bus.best_err !== 14'd120) begin errors++; $display("FAIL done_to_idle got select=%0d done=%0b best=%0d exp 0 0 120", bus.select, bus.done, bus.best_err); end
        step(1);
        start_game(14'd2000);
        checks++; if (bus.total_err !== 16'd0 || bus.round_idx !== 3'd0 || bus.best_err !== 14'd120) begin errors++; $display("FAIL new_game got total=%0d idx=%0d best=%0d exp 0 0 120", bus.total_err, bus.round_idx, bus.best_err); end
    endtask

    task automatic test_all_timeout();
        do_reset();
        start_game(14'd4000);
        for (int r = 0; r < 3; r++) begin
            enter_count();
            bus.count_val = 14'd9999;
            step(1);
            checks++; if (bus.round_err !== 14'd9999 || bus.select !== 2'd3) begin errors++; $display("FAIL to_round%0d got err=%0d select=%0d exp 9999 3", r, bus.round_err, bus.select); end
            step(1);
            step(GAP);
        end
        checks++; if (bus.done !== 1'b1 || bus.total_err !== 16'd29997 || bus.best_err !== 14'd9999) begin errors++; $display("FAIL to_game got done=%0b total=%0d best=%0d exp 1 29997 9999", bus.done, bus.total_err, bus.best_err); end
        press_step();
        checks++; if (bus.select !== 2'd0 || bus.best_err !== 14'd9999) begin errors++; $display("FAIL to_idle got select=%0d best=%0d exp 0 9999", bus.select, bus.best_err); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        start_game(14'd6000);
        enter_count();
        checks++; if (bus.cnt_en !== 1'b1) begin errors++; $display("FAIL mid_pre_en got %0b exp 1", bus.cnt_en); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.select !== 2'd0 || bus.cnt_en !== 1'b0 || bus.target !== 14'd0 || bus.best_err !== 14'd9999) begin errors++; $display("FAIL mid_reset got select=%0d en=%0b target=%0d best=%0d exp 0 0 0 9999", bus.select, bus.cnt_en, bus.target, bus.best_err); end
        step(1);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        bus.btn_go = 1'b1;
        bus.rand_val = 14'd0;
        bus.count_val = 14'd0;
        test_reset();
        test_target_fold();
        test_early_press();
        test_round_scoring();
        test_all_timeout();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reaction_round_sequencer.md
Name: reaction_round_sequencer

Overview:
- Multi-round controller for the reaction-game datapath: sequences target latch, counting and scoring phases over NUM_ROUNDS rounds.
- Drives the stage code, counter clear/enable and target value to the display/counter datapath; accumulates total and best error.
- Sits between the debounced/synchronized button and the counting datapath; single clock domain (100 MHz system clock).

Parameters:
- NUM_ROUNDS, 3, rounds per game (1..7)
- GAP_TICKS, 20000000, clk cycles spent in GAP after each score (0.2 s)
- TIMEOUT_COUNT, 9999, count_val at which a round ends without a press
- MIN_SHOW_TICKS, 50000000, minimum SHOW dwell before a press is accepted

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- btn_go  in  1  synchronized, debounced level of the go button
- rand  in  14  free-running random value
- count_val  in  14  current value of the counting datapath
- select  out  2  stage code: 0 idle, 1 target, 2 counting, 3 score/gap/done
- target  out  14  latched target, always 1000..9999 after latch
- cnt_clr  out  1  one-cycle clear pulse to counter
- cnt_en  out  1  counter enable
- round_idx  out  3  current round, 0-based
- round_err  out  14  |count_val - target| of last round
- total_err  out  16  saturating sum of round errors this game
- best_err  out  14  minimum round_err since reset
- done  out  1  high in DONE state

Behaviour:
- Asynchronous reset: state=IDLE, select=0, target=0, cnt_clr=0, cnt_en=0, round_idx=0, round_err=0, total_err=0, best_err=9999, done=0, btn_q=1 (held button at reset does not produce a press).
- press = btn_go & ~btn_q; btn_q registered every cycle. Presses not consumed in the current state are dropped, never queued.
- Target fold: t=rand; if t<1000 then t+=1000; if t>9999 then t-=7000.
- IDLE (select 0): on press -> SHOW; clear total_err, round_idx=0; latch target from fold(rand); clear dwell counter.
- SHOW (select 1): dwell counter increments. Press with dwell>=MIN_SHOW_TICKS -> COUNT, cnt_clr=1 for exactly that transition cycle. Earlier presses are ignored.
- COUNT (select 2, cnt_en=1): a press -> round_err<=|count_val-target| computed from the same-cycle count_val, cnt_en deasserts next cycle, -> SCORE. If count_val==TIMEOUT_COUNT with no press -> round_err<=9999 -> SCORE. A press in the same cycle as the timeout wins, giving the normal error.
- SCORE (select 3, 1 cycle): total_err<=min(total_err+round_err, 65535); best_err<=min(best_err, round_err); clear gap counter -> GAP.
- GAP (select 3): after GAP_TICKS cycles: if round_idx==NUM_ROUNDS-1 -> DONE; else round_idx+1, re-latch target from fold(rand), clear dwell -> SHOW.
- DONE (select 3, done=1): outputs hold. A press -> IDLE. best_err persists across games; only rst clears it.
- Arithmetic: abs difference in 14 bits, unsigned; total accumulation in 17 bits, then saturate.
- rst mid-game returns to the reset state immediately; the counter may hold a stale value until the next cnt_clr.

Optional Feature:
- FALSE_START_EN: when defined, a press in SHOW before MIN_SHOW_TICKS is a false start. It sets round_err=9999, skips COUNT (no cnt_clr/cnt_en) and goes -> SCORE.
- When undefined, such presses are ignored as described above.

Test Plan:
- Reset with btn_go held high -> no press, state IDLE, best_err=9999. Release and press -> select=1, target in 1000..9999.
- rand=500 -> target=1500. rand=12000 -> target=5000. rand=9999 -> target=9999.
- target=5000, press at count_val=5120 -> round_err=120, total_err=120, best_err=120. After GAP_TICKS, round_idx=1 and select=1.
- No press in COUNT until count_val=9999 -> round_err=9999. A press coincident with count_val=9999 and target=9000 -> round_err=999.
- Three rounds with errors 9999,9999,9999 -> total_err=29997, done=1 after the third GAP. A press -> IDLE; best_err retained.
- Press 10 cycles into SHOW: without FALSE_START_EN -> stays SHOW, no cnt_clr. With FALSE_START_EN -> round_err=9999, SCORE, cnt_en never asserted.
